// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68010 slave-side bus responder.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_BERR  = 3'd4,
        ST_DRAIN = 3'd5
    } state_e;

    localparam logic [2:0] FC_USER_DATA = 3'b001;
    localparam logic [2:0] FC_USER_PROG = 3'b010;
    localparam logic [2:0] FC_SUPV_DATA = 3'b101;
    localparam logic [2:0] FC_SUPV_PROG = 3'b110;
    localparam logic [2:0] FC_CPU_SPACE = 3'b111;

    localparam logic [1:0] BE_UPPER = 2'b10;
    localparam logic [1:0] BE_LOWER = 2'b01;
    localparam logic [1:0] BE_WORD  = 2'b11;

    // CPU space (IACK, breakpoint) cycles never select a memory window.
    function automatic logic addr_hit(input logic [22:0] addr,
                                      input logic [2:0]  fc,
                                      input logic [23:0] base,
                                      input logic [23:0] mask);
        return ((({addr, 1'b0}) & mask) == (base & mask)) && (fc != FC_CPU_SPACE);
    endfunction

endpackage

// File: rtl/m68k_strobe_sync.sv
// Multi-flop synchronizer for an active-low bus strobe; resets to the negated level.
module m68k_strobe_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/m68k_bus_responder.sv
// 68010 asynchronous-bus slave: decodes a window, runs a level req/ack to a
// backend and answers with DTACK (plus read data) or BERR on backend timeout.
module m68k_bus_responder
    import m68k_bus_pkg::*;
#(
    parameter logic [23:0] BASE        = 24'h000000,
    parameter logic [23:0] MASK        = 24'hF00000,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        C100,
    input  logic        reset,
    input  logic        as_n,
    input  logic        rw_n,
    input  logic        uds_n,
    input  logic        lds_n,
    input  logic [2:0]  fc,
    input  logic [22:0] addr,
    input  logic [15:0] d_in,
    output logic [15:0] d_out,
    output logic        d_oe,
    output logic        dtack_n,
    output logic        berr_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]  WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic as_sn, uds_sn, lds_sn;
    logic as_act, uds_act, lds_act;

    m68k_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_as  (.clk_i(C100), .rst_i(reset), .d_i(as_n),  .q_o(as_sn));
    m68k_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uds (.clk_i(C100), .rst_i(reset), .d_i(uds_n), .q_o(uds_sn));
    m68k_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lds (.clk_i(C100), .rst_i(reset), .d_i(lds_n), .q_o(lds_sn));

    assign as_act  = ~as_sn;
    assign uds_act = ~uds_sn;
    assign lds_act = ~lds_sn;

    state_e        state_q, state_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [3:0]    ws_cnt_q, ws_cnt_d;
    logic          we_q, we_d;
    logic [22:0]   addr_q, addr_d;
    logic [1:0]    be_q, be_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   rdata_q, rdata_d;

    always_ff @(posedge C100 or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            to_cnt_q <= '0;
            ws_cnt_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            ws_cnt_q <= ws_cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        ws_cnt_d = ws_cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                to_cnt_d = '0;
                ws_cnt_d = '0;
                if (as_act && (uds_act || lds_act) && addr_hit(addr, fc, BASE, MASK)) begin
                    we_d    = ~rw_n;
                    addr_d  = addr;
                    be_d    = {uds_act, lds_act};
                    wdata_d = d_in;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Ack beats both AS negation and timeout in the same cycle.
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
                end else if (!as_act) begin
                    state_d = ST_DRAIN;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_BERR;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            ST_WAIT: begin
                if (!as_act) begin
                    state_d = ST_IDLE;
                end else if (ws_cnt_q == WS_LAST) begin
                    state_d = ST_ACK;
                end else begin
                    ws_cnt_d = ws_cnt_q + 4'd1;
                end
            end
            ST_ACK, ST_BERR: begin
                if (!as_act) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (mem_ack || (to_cnt_q == TO_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus-facing outputs decode straight from state so reset releases them at once.
    assign dtack_n   = (state_q != ST_ACK);
    assign berr_n    = (state_q != ST_BERR);
    assign d_oe      = (state_q == ST_ACK) && !we_q;
    assign d_out     = d_oe ? rdata_q : '0;
    assign mem_req   = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench: vector table of single bus cycles plus multi-cycle corner sequences.
module tb_m68k_bus_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        as_n = 1'b1, rw_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1;
    logic [2:0]  fc = 3'b101;
    logic [22:0] addr = '0;
    logic [15:0] d_in = '0, rdata = '0;
    logic        mem_ack0 = 1'b0, mem_ack3 = 1'b0;
    logic        ack_en0 = 1'b1, ack_en3 = 1'b1;

    logic [15:0] d_out0, d_out3, wdata0, wdata3;
    logic        d_oe0, d_oe3, dtack0, dtack3, berr0, berr3, req0, req3, we0, we3;
    logic [22:0] maddr0, maddr3;
    logic [1:0]  be0, be3;

    int n_cmp  = 0;
    int n_fail = 0;
    int req_cnt0 = 0;

    always #5 clk = ~clk;

    m68k_bus_responder #(.BASE(24'h000000), .MASK(24'hF00000), .WAIT_STATES(0),
                         .TIMEOUT(64), .SYNC_STAGES(2)) dut0 (
        .C100(clk), .reset(reset), .as_n(as_n), .rw_n(rw_n), .uds_n(uds_n), .lds_n(lds_n),
        .fc(fc), .addr(addr), .d_in(d_in), .d_out(d_out0), .d_oe(d_oe0), .dtack_n(dtack0),
        .berr_n(berr0), .mem_req(req0), .mem_we(we0), .mem_addr(maddr0), .mem_be(be0),
        .mem_wdata(wdata0), .mem_rdata(rdata), .mem_ack(mem_ack0));

    m68k_bus_responder #(.BASE(24'h000000), .MASK(24'hF00000), .WAIT_STATES(3),
                         .TIMEOUT(64), .SYNC_STAGES(2)) dut3 (
        .C100(clk), .reset(reset), .as_n(as_n), .rw_n(rw_n), .uds_n(uds_n), .lds_n(lds_n),
        .fc(fc), .addr(addr), .d_in(d_in), .d_out(d_out3), .d_oe(d_oe3), .dtack_n(dtack3),
        .berr_n(berr3), .mem_req(req3), .mem_we(we3), .mem_addr(maddr3), .mem_be(be3),
        .mem_wdata(wdata3), .mem_rdata(rdata), .mem_ack(mem_ack3));

    // Backend model: acknowledges in the first cycle it sees a request.
    always @(negedge clk) begin
        mem_ack0 = ack_en0 && req0;
        mem_ack3 = ack_en3 && req3;
        if (req0) req_cnt0++;
    end

    typedef struct {
        string       name;
        logic [23:0] a;
        logic [2:0]  fc;
        logic        rw_n, uds_n, lds_n;
        logic [15:0] din, rdata;
        logic        hit, we;
        logic [1:0]  be;
        logic [22:0] maddr;
        logic [15:0] wdata, dout;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_cycle(input logic [23:0] a, input logic [2:0] f, input logic r,
                               input logic u, input logic l, input logic [15:0] di,
                               input logic [15:0] rd);
        addr = a[23:1]; fc = f; rw_n = r; uds_n = u; lds_n = l; d_in = di; rdata = rd;
        as_n = 1'b0;
    endtask

    task automatic end_cycle();
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    endtask

    task automatic do_vec(input vec_t v);
        int rc;
        @(negedge clk);
        start_cycle(v.a, v.fc, v.rw_n, v.uds_n, v.lds_n, v.din, v.rdata);
        rc = req_cnt0;
        repeat (3) @(negedge clk);
        chk({v.name, ":dtack_early"}, 32'(dtack0), 32'd1);
        @(negedge clk);
        if (v.hit) begin
            chk({v.name, ":dtack"}, 32'(dtack0), 32'd0);
            chk({v.name, ":berr"},  32'(berr0),  32'd1);
            chk({v.name, ":we"},    32'(we0),    32'(v.we));
            chk({v.name, ":be"},    32'(be0),    32'(v.be));
            chk({v.name, ":maddr"}, 32'(maddr0), 32'(v.maddr));
            chk({v.name, ":wdata"}, 32'(wdata0), 32'(v.wdata));
            chk({v.name, ":d_oe"},  32'(d_oe0),  32'(v.rw_n));
            chk({v.name, ":d_out"}, 32'(d_out0), 32'(v.dout));
        end else begin
            chk({v.name, ":dtack"}, 32'(dtack0), 32'd1);
            chk({v.name, ":berr"},  32'(berr0),  32'd1);
            chk({v.name, ":req"},   32'(req_cnt0 - rc), 32'd0);
        end
        end_cycle();
        repeat (2) @(negedge clk);
        chk({v.name, ":dtack_hold"}, 32'(dtack0), 32'(!v.hit));
        @(negedge clk);
        chk({v.name, ":dtack_rel"}, 32'(dtack0), 32'd1);
        chk({v.name, ":d_oe_rel"},  32'(d_oe0),  32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{"wrd_rd",  24'h000100, 3'b101, 1'b1, 1'b0, 1'b0, 16'h1234, 16'hBEEF,
                    1'b1, 1'b0, 2'b11, 23'h000080, 16'h1234, 16'hBEEF};
        vecs[1] = '{"byte_wr", 24'h000203, 3'b001, 1'b0, 1'b1, 1'b0, 16'h00A5, 16'hFFFF,
                    1'b1, 1'b1, 2'b01, 23'h000101, 16'h00A5, 16'h0000};
        vecs[2] = '{"up_rd",   24'h0FFFFE, 3'b001, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h5A00,
                    1'b1, 1'b0, 2'b10, 23'h07FFFF, 16'h0000, 16'h5A00};
        vecs[3] = '{"wrd_wr",  24'h0ABCDE, 3'b101, 1'b0, 1'b0, 1'b0, 16'hC3C3, 16'h0000,
                    1'b1, 1'b1, 2'b11, 23'h055E6F, 16'hC3C3, 16'h0000};
        vecs[4] = '{"miss4",   24'h400000, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1111,
                    1'b0, 1'b0, 2'b00, 23'h000000, 16'h0000, 16'h0000};
        vecs[5] = '{"cpu_sp",  24'h000100, 3'b111, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h2222,
                    1'b0, 1'b0, 2'b00, 23'h000000, 16'h0000, 16'h0000};
        vecs[6] = '{"miss1",   24'h100000, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h3333,
                    1'b0, 1'b0, 2'b00, 23'h000000, 16'h0000, 16'h0000};
        vecs[7] = '{"sp_rd0",  24'h000000, 3'b110, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001,
                    1'b1, 1'b0, 2'b11, 23'h000000, 16'h0000, 16'h0001};

        @(negedge clk);
        chk("rst:dtack", 32'(dtack0), 32'd1);
        chk("rst:berr",  32'(berr0),  32'd1);
        chk("rst:d_oe",  32'(d_oe0),  32'd0);
        chk("rst:d_out", 32'(d_out0), 32'd0);
        chk("rst:req",   32'(req0),   32'd0);
        chk("rst:we",    32'(we0),    32'd0);
        chk("rst:maddr", 32'(maddr0), 32'd0);
        chk("rst:be",    32'(be0),    32'd0);
        chk("rst:wdata", 32'(wdata0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) do_vec(vecs[i]);

        // Wait states: DTACK three clocks later than the zero-wait instance.
        @(negedge clk);
        start_cycle(24'h000100, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hCAFE);
        repeat (3) @(negedge clk);
        chk("ws0:early", 32'(dtack0), 32'd1);
        @(negedge clk);
        chk("ws0:dtack", 32'(dtack0), 32'd0);
        repeat (2) @(negedge clk);
        chk("ws3:early", 32'(dtack3), 32'd1);
        @(negedge clk);
        chk("ws3:dtack", 32'(dtack3), 32'd0);
        chk("ws3:d_oe",  32'(d_oe3),  32'd1);
        chk("ws3:d_out", 32'(d_out3), 32'hCAFE);
        end_cycle();
        repeat (3) @(negedge clk);
        chk("ws3:rel", 32'(dtack3), 32'd1);
        repeat (2) @(negedge clk);

        // Timeout: no ack ever, BERR after 64 REQ clocks.
        ack_en0 = 1'b0; ack_en3 = 1'b0;
        @(negedge clk);
        start_cycle(24'h000400, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (66) @(negedge clk);
        chk("to:berr_early", 32'(berr0), 32'd1);
        chk("to:req_held",   32'(req0),  32'd1);
        @(negedge clk);
        chk("to:berr",  32'(berr0),  32'd0);
        chk("to:req",   32'(req0),   32'd0);
        chk("to:dtack", 32'(dtack0), 32'd1);
        chk("to:berr3", 32'(berr3),  32'd0);
        end_cycle();
        repeat (2) @(negedge clk);
        chk("to:berr_hold", 32'(berr0), 32'd0);
        @(negedge clk);
        chk("to:berr_rel", 32'(berr0), 32'd1);
        repeat (2) @(negedge clk);

        // AS negated during REQ: request held until the late ack, no DTACK.
        @(negedge clk);
        start_cycle(24'h000100, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h7777);
        repeat (4) @(negedge clk);
        chk("dr:req", 32'(req0), 32'd1);
        end_cycle();
        repeat (8) @(negedge clk);
        chk("dr:req_held",  32'(req0),   32'd1);
        chk("dr:req3_held", 32'(req3),   32'd1);
        chk("dr:dtack",     32'(dtack0), 32'd1);
        chk("dr:berr",      32'(berr0),  32'd1);
        ack_en0 = 1'b1; ack_en3 = 1'b1;
        repeat (3) @(negedge clk);
        chk("dr:req_drop",  32'(req0),   32'd0);
        chk("dr:req3_drop", 32'(req3),   32'd0);
        chk("dr:dtack_end", 32'(dtack0), 32'd1);
        chk("dr:d_oe",      32'(d_oe0),  32'd0);
        repeat (2) @(negedge clk);

        // Reset while DTACK is asserted releases the bus without a clock edge.
        @(negedge clk);
        start_cycle(24'h000100, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hA5A5);
        repeat (5) @(negedge clk);
        chk("rs:dtack", 32'(dtack0), 32'd0);
        chk("rs:d_oe",  32'(d_oe0),  32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rs:dtack_rel", 32'(dtack0), 32'd1);
        chk("rs:d_oe_rel",  32'(d_oe0),  32'd0);
        chk("rs:d_out",     32'(d_out0), 32'd0);
        chk("rs:maddr",     32'(maddr0), 32'd0);
        chk("rs:be",        32'(be0),    32'd0);
        @(negedge clk);
        reset = 1'b0;
        end_cycle();
        repeat (4) @(negedge clk);
        chk("rs:idle_dtack", 32'(dtack0), 32'd1);
        chk("rs:idle_req",   32'(req0),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/m68k_bus_responder.md
Name: m68k_bus_responder

Overview:
Slave-side 68010 asynchronous bus interface: the memory/peripheral end of the cycles generated by the CPU bus-master model.
- Decodes AS/UDS/LDS/R/W and the address window.
- Runs a level req/ack transaction to a local memory or register backend.
- Drives read data and DTACK, or BERR on backend timeout.
- Sits on the P_* bus alongside the CPU model; one instance per slave window.

Parameters:
BASE, 24'h000000, window base byte address (bit 0 ignored)
MASK, 24'hF00000, address bits compared against BASE
WAIT_STATES, 0, extra clocks between mem_ack and DTACK assertion (0..15)
TIMEOUT, 64, clocks in REQ without mem_ack before BERR (>=2)
SYNC_STAGES, 2, flops on as_n/uds_n/lds_n (>=2)

Ports:
C100  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high
as_n  in  1  address strobe from bus
rw_n  in  1  1=read, 0=write
uds_n  in  1  upper data strobe (D15..D8)
lds_n  in  1  lower data strobe (D7..D0)
fc  in  3  function code
addr  in  23  A23..A1
d_in  in  16  data bus as seen by slave
d_out  out  16  read data to bus
d_oe  out  1  drive enable for d_out
dtack_n  out  1  data acknowledge
berr_n  out  1  bus error
mem_req  out  1  backend request, level
mem_we  out  1  1=write
mem_addr  out  23  latched A23..A1
mem_be  out  2  {upper,lower} byte enables = {~uds_n,~lds_n}
mem_wdata  out  16  latched write data
mem_rdata  in  16  backend read data, valid with mem_ack
mem_ack  in  1  backend completion, sampled only while mem_req=1

Behaviour:
- Clock C100; reset asynchronous, active-high. Reset forces IDLE; sync flops=1; dtack_n=1, berr_n=1, d_oe=0, d_out=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, counters=0.
- as_s/uds_s/lds_s = synchronized strobes; addr, rw_n, fc, d_in sampled directly (stable once synced strobe is seen).
- hit = ((addr,1'b0) & MASK) == (BASE & MASK) and fc != 3'b111 (CPU space/IACK never hits).
- States: IDLE, REQ, WAIT, ACK, BERR, DRAIN.
- IDLE: when as_s & (uds_s|lds_s) & hit: latch mem_addr, mem_we=~rw_n, mem_be, mem_wdata=d_in; ->REQ. Miss or AS-only: stay IDLE, no response ever driven.
- REQ: mem_req=1, timeout counter increments.
  - mem_ack=1: latch mem_rdata; ->WAIT if WAIT_STATES>0 else ->ACK.
  - as_s negated before ack: ->DRAIN.
  - Counter reaches TIMEOUT-1 without ack: ->BERR. Ack in that same cycle wins (->WAIT/ACK).
- WAIT: count WAIT_STATES clocks, then ->ACK. as_s negated: ->IDLE, no DTACK.
- ACK: dtack_n=0. For reads, d_oe=1 and d_out=latched data. Held until as_s=0, then ->IDLE; dtack_n=1 and d_oe=0 registered on that same edge.
- BERR: mem_req=0, berr_n=0 until as_s=0, then ->IDLE. A late mem_ack is ignored.
- DRAIN: mem_req held until mem_ack (backend transactions never torn), then ->IDLE; no DTACK or data driven. Timeout in DRAIN: ->IDLE.
- mem_req falls on the edge mem_ack is sampled; a new request needs a new AS assertion (back-to-back cycles need an AS negation in between).
- Latency (SYNC_STAGES=2, WAIT_STATES=0, ack in first REQ cycle): dtack_n low 4 edges after strobes fall; each wait state adds 1.
- Reset mid-cycle: immediate return to idle outputs; the backend must tolerate an abandoned mem_req.

Decomposition:
- Package m68k_bus_pkg: state enum; FC_CPU_SPACE=3'b111 and other FC codes; BE_UPPER=2'b10, BE_LOWER=2'b01, BE_WORD=2'b11.
- Sub-module m68k_strobe_sync (SYNC_STAGES-deep synchronizer, reset to 1), instanced for as_n, uds_n, lds_n.

Test Plan:
- Word read 0x000100, BASE=0, mem_ack next cycle, mem_rdata=16'hBEEF -> mem_be=2'b11, mem_we=0, dtack_n low 4 edges after strobes, d_out=BEEF with d_oe=1, both released the edge after as_s negates.
- Byte write 0x000203 (lds only), d_in=16'h00A5 -> mem_we=1, mem_be=2'b01, mem_addr=23'h000101, mem_wdata=00A5, d_oe stays 0.
- WAIT_STATES=3, read -> dtack_n falls exactly 3 clocks later than the WAIT_STATES=0 case.
- mem_ack never asserted, TIMEOUT=64 -> berr_n low after 64 REQ clocks, mem_req drops, dtack_n stays 1; release on AS negate.
- Address 0x400000 with MASK=F00000, and fc=3'b111 at a hit address -> no mem_req, dtack_n/berr_n stay 1.
- AS negated during REQ, ack 5 clocks later -> mem_req held until ack, no DTACK; reset asserted in ACK -> dtack_n=1, d_oe=0 immediately.
